// File: rtl/operation_encoder.sv
// operation_encoder: synchronises and debounces the three front-panel buttons and
// turns presses into 2-bit operation codes held until the counter acknowledges them.
module operation_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_minute,
    input  logic       btn_zero,
    input  logic       btn_reset,
    input  logic       encoder_reset,
    output logic [1:0] operation,
    output logic       busy
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPW = $clog2(REPEAT_DELAY + 1);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPW-1:0] RP_FIRE   = RPW'(REPEAT_DELAY);
    localparam logic [RPW-1:0] RP_RELOAD = RPW'(REPEAT_DELAY - REPEAT_PERIOD + 1);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_ZERO = 2'b01;
    localparam logic [1:0] OP_MIN  = 2'b10;
    localparam logic [1:0] OP_RST  = 2'b11;

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    // Button bit order everywhere: [0] minute, [1] zero, [2] reset.
    logic [2:0]     sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]     db_q, db_d, db_prev_q, db_prev_d;
    logic [DBW-1:0] db_cnt_q [3];
    logic [DBW-1:0] db_cnt_d [3];
    logic [RPW-1:0] rep_cnt_q, rep_cnt_d;
    state_t         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic           pend_valid_q, pend_valid_d;
    logic [1:0]     pend_code_q, pend_code_d;
    logic           busy_q, busy_d;

    logic [2:0]     press;
    logic           rep_run, rep_tick;
    logic           ev_valid;
    logic [1:0]     ev_code;
    logic           merge_valid;
    logic [1:0]     merge_code;

    always_comb begin
        sync1_d = {btn_reset, btn_zero, btn_minute};
        sync2_d = sync1_q;
        db_d    = db_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) db_d[i] = sync2_q[i];
                else                        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
        db_prev_d = db_q;
        press     = db_q & ~db_prev_q;

        // Repeat counter measures time since minute went high with zero low.
        rep_run   = db_q[0] & ~db_q[1];
        rep_tick  = rep_run && (rep_cnt_q == RP_FIRE);
        rep_cnt_d = '0;
        if (rep_run) rep_cnt_d = rep_tick ? RP_RELOAD : rep_cnt_q + 1'b1;

        ev_valid = 1'b1;
        ev_code  = OP_NONE;
        if (press[2])                                         ev_code = OP_RST;
        else if ((press[0] & db_q[1]) | (press[1] & db_q[0])) ev_code = OP_RST;
        else if (press[0] | rep_tick)                         ev_code = OP_MIN;
        else if (press[1])                                    ev_code = OP_ZERO;
        else                                                  ev_valid = 1'b0;

        merge_valid = pend_valid_q;
        merge_code  = pend_code_q;
        if (ev_valid && (!pend_valid_q || ev_code == OP_RST)) begin
            merge_valid = 1'b1;
            merge_code  = ev_code;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        pend_valid_d = pend_valid_q;
        pend_code_d  = pend_code_q;
        case (state_q)
            IDLE: begin
                if (ev_valid) begin
                    op_d    = ev_code;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                pend_valid_d = merge_valid;
                pend_code_d  = merge_code;
                if (encoder_reset) begin
                    op_d    = OP_NONE;
                    state_d = GAP;
                end
            end
            GAP: begin
                // An event landing in the gap cycle itself is picked up here too.
                if (merge_valid) begin
                    op_d         = merge_code;
                    pend_valid_d = 1'b0;
                    pend_code_d  = OP_NONE;
                    state_d      = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) | pend_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            db_q         <= '0;
            db_prev_q    <= '0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
            rep_cnt_q    <= '0;
            state_q      <= IDLE;
            op_q         <= OP_NONE;
            pend_valid_q <= 1'b0;
            pend_code_q  <= OP_NONE;
            busy_q       <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_q         <= db_d;
            db_prev_q    <= db_prev_d;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
            rep_cnt_q    <= rep_cnt_d;
            state_q      <= state_d;
            op_q         <= op_d;
            pend_valid_q <= pend_valid_d;
            pend_code_q  <= pend_code_d;
            busy_q       <= busy_d;
        end
    end

    assign operation = op_q;
    assign busy      = busy_q;
endmodule
